// File: rtl/argmax_pkg.sv
// argmax_pkg: shared candidate type and elaboration helpers for argmax_tree.
//   cand_t    : {signed value, index} pair carried through the tournament tree
//   PAD_VALUE : score used for missing leaves (carrier minimum, can never win)
//   stages_f  : number of registered tree levels for n classes
//   cnt_f     : candidate count entering level s (ceil(n / 2^s))
//   pick_f    : node compare, right wins only on strictly greater signed value
package argmax_pkg;

  // Scores are sign-extended into a fixed carrier; index carrier covers 64 classes.
  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_IDX_W  = 6;

  typedef struct packed {
    logic signed [MAX_DATA_W-1:0] value;
    logic        [MAX_IDX_W-1:0]  index;
  } cand_t;

  localparam logic signed [MAX_DATA_W-1:0] PAD_VALUE = {1'b1, {(MAX_DATA_W-1){1'b0}}};

  function automatic int unsigned stages_f(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_f(input int unsigned n, input int unsigned s);
    return (n + (32'd1 << s) - 1) >> s;
  endfunction

  // Ties keep the left (lower-index) candidate.
  function automatic cand_t pick_f(input cand_t left, input cand_t right);
    return (right.value > left.value) ? right : left;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// argmax_node: one compare-and-register tournament node.
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   en_i          : load enable (low while the tree is stalled)
//   left_i        : lower-index candidate
//   right_i       : higher-index candidate (or padding)
//   cand_o        : registered winner
// KEEP_VALUE=0 drops the value register where no later compare reads it.
module argmax_node
  import argmax_pkg::*;
#(
  parameter bit KEEP_VALUE = 1'b1
) (
  input  logic  clock,
  input  logic  resetn,
  input  logic  en_i,
  input  cand_t left_i,
  input  cand_t right_i,
  output cand_t cand_o
);

  cand_t cand_d;
  cand_t cand_q;

  // Winner selection; value forced to zero when it is not carried onward.
  always_comb begin
    cand_d = pick_f(left_i, right_i);
    if (!KEEP_VALUE) begin
      cand_d.value = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cand_q <= '0;
    end else if (en_i) begin
      cand_q <= cand_d;
    end
  end

  assign cand_o = cand_q;

endmodule

// File: rtl/argmax_tree.sv
// argmax_tree: pipelined arg-max over N_CLASSES signed scores, one vector per cycle.
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake; in_ready = ~stall (combinational)
//   in_data              : packed scores, class k at [k*DATA_W +: DATA_W]
//   out_valid / out_ready: output handshake, outputs held while stalled
//   out_index            : winning class (lowest index on ties)
//   out_value            : winning score, only when ARGMAX_VALUE_OUT_EN is defined
// Latency is stages_f(N_CLASSES) cycles; N_CLASSES in 2..64, DATA_W up to 64.
module argmax_tree
  import argmax_pkg::*;
#(
  parameter int unsigned N_CLASSES = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = $clog2(N_CLASSES)
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_CLASSES*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_index
`ifdef ARGMAX_VALUE_OUT_EN
  ,
  output logic [DATA_W-1:0]           out_value
`endif
);

  localparam int unsigned STAGES = stages_f(N_CLASSES);

`ifdef ARGMAX_VALUE_OUT_EN
  localparam bit VALUE_OUT = 1'b1;
`else
  localparam bit VALUE_OUT = 1'b0;
`endif

  // Padding index is all-ones, which is >= N_CLASSES whenever padding exists.
  localparam logic [MAX_IDX_W-1:0] PAD_INDEX = MAX_IDX_W'((2 ** IDX_W) - 1);
  localparam cand_t PAD_CAND = '{value: PAD_VALUE, index: PAD_INDEX};

  logic              stall_c;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  cand_t             tree_q [STAGES][N_CLASSES];
  cand_t             fin_cand;
  logic              unused_fin;

  // Global stall: the whole pipe freezes while a result waits for the sink.
  assign stall_c  = valid_q[STAGES-1] & ~out_ready;
  assign in_ready = ~stall_c;

  // Valid bits shift alongside the data; bubbles are kept, not compressed.
  always_comb begin
    valid_d = valid_q;
    if (!stall_c) begin
      valid_d[0] = in_valid;
      for (int s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tournament tree: level s has ceil(N/2^(s+1)) nodes; odd counts pad on the right.
  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int unsigned N_IN  = cnt_f(N_CLASSES, s);
    localparam int unsigned N_OUT = cnt_f(N_CLASSES, s + 1);
    localparam bit          KEEP  = ((s + 1) < STAGES) || VALUE_OUT;

    for (genvar k = 0; k < N_CLASSES; k++) begin : g_node
      if (k < N_OUT) begin : g_cmp
        cand_t left_c;
        cand_t right_c;

        if (s == 0) begin : g_leaf
          assign left_c = '{value: MAX_DATA_W'(signed'(in_data[2*k*DATA_W +: DATA_W])),
                            index: MAX_IDX_W'(2*k)};
          if ((2*k + 1) < N_IN) begin : g_right
            assign right_c = '{value: MAX_DATA_W'(signed'(in_data[(2*k+1)*DATA_W +: DATA_W])),
                               index: MAX_IDX_W'(2*k + 1)};
          end else begin : g_pad
            assign right_c = PAD_CAND;
          end
        end else begin : g_inner
          assign left_c = tree_q[s-1][2*k];
          if ((2*k + 1) < N_IN) begin : g_right
            assign right_c = tree_q[s-1][2*k+1];
          end else begin : g_pad
            assign right_c = PAD_CAND;
          end
        end

        argmax_node #(
          .KEEP_VALUE(KEEP)
        ) u_node (
          .clock  (clock),
          .resetn (resetn),
          .en_i   (~stall_c),
          .left_i (left_c),
          .right_i(right_c),
          .cand_o (tree_q[s][k])
        );
      end else begin : g_idle
        assign tree_q[s][k] = '0;
      end
    end
  end

  // Outputs come straight from the final node register.
  assign fin_cand   = tree_q[STAGES-1][0];
  assign out_valid  = valid_q[STAGES-1];
  assign out_index  = fin_cand.index[IDX_W-1:0];
`ifdef ARGMAX_VALUE_OUT_EN
  assign out_value  = fin_cand.value[DATA_W-1:0];
`endif
  // Carrier bits above the configured widths are sign/zero extension only.
  assign unused_fin = ^fin_cand;

endmodule

// File: tb/tb_argmax_tree.sv
// tb_argmax_tree: directed self-checking bench for argmax_tree (N=8, N=5, N=2 instances).
module tb_argmax_tree;

  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic resetn;

  logic            in_valid8, in_ready8, out_valid8, out_ready8;
  logic [8*DW-1:0] in_data8;
  logic [2:0]      out_index8;
  logic            in_valid5, in_ready5, out_valid5;
  logic [5*DW-1:0] in_data5;
  logic [2:0]      out_index5;
  logic            in_valid2, in_ready2, out_valid2;
  logic [2*DW-1:0] in_data2;
  logic [0:0]      out_index2;
`ifdef ARGMAX_VALUE_OUT_EN
  logic [DW-1:0]   out_value8, out_value5, out_value2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  argmax_tree #(.N_CLASSES(8), .DATA_W(DW)) dut8 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_index(out_index8)
`ifdef ARGMAX_VALUE_OUT_EN
    , .out_value(out_value8)
`endif
  );

  argmax_tree #(.N_CLASSES(5), .DATA_W(DW)) dut5 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(1'b1), .out_index(out_index5)
`ifdef ARGMAX_VALUE_OUT_EN
    , .out_value(out_value5)
`endif
  );

  argmax_tree #(.N_CLASSES(2), .DATA_W(DW)) dut2 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_index(out_index2)
`ifdef ARGMAX_VALUE_OUT_EN
    , .out_value(out_value2)
`endif
  );

  task automatic drive8(input int v [8]);
    for (int k = 0; k < 8; k++) in_data8[k*DW +: DW] = v[k];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; out_ready8 = 1'b1;
    in_valid8 = 1'b1; in_valid5 = 1'b1; in_valid2 = 1'b1;
    in_data8 = '1; in_data5 = '1; in_data2 = '1;
    tick(); tick();
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8: got %b expected 0", out_valid8); end
    checks++; if (out_index8 !== 3'd0) begin errors++; $display("FAIL reset_index8: got %0d expected 0", out_index8); end
    checks++; if (out_valid5 !== 1'b0 || out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid5_2: got %b%b expected 00", out_valid5, out_valid2); end
    resetn = 1'b1; in_valid8 = 1'b0; in_valid5 = 1'b0; in_valid2 = 1'b0;
    tick();
    checks++; if ({in_ready8, in_ready5, in_ready2} !== 3'b111) begin errors++; $display("FAIL reset_in_ready: got %b expected 111", {in_ready8, in_ready5, in_ready2}); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_no_stale: got %b expected 0", out_valid8); end
  endtask

  task automatic test_basic();
    drive8('{5, -3, 12, 7, 12, 0, -100, 11});
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) in_valid8 = 1'b0;
      checks++; if (out_valid8 !== (c == 3)) begin errors++; $display("FAIL basic_latency_c%0d: got %b expected %b", c, out_valid8, (c == 3)); end
    end
    checks++; if (out_index8 !== 3'd2) begin errors++; $display("FAIL basic_index: got %0d expected 2", out_index8); end
`ifdef ARGMAX_VALUE_OUT_EN
    checks++; if (out_value8 !== 32'd12) begin errors++; $display("FAIL basic_value: got %0d expected 12", out_value8); end
`endif
    tick();
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b expected 0", out_valid8); end
  endtask

  task automatic test_ties();
    logic [DW-1:0] fill [2];
    fill[0] = 32'hFFFF_FFFF;
    fill[1] = 32'h8000_0000;
    for (int t = 0; t < 2; t++) begin
      in_data8 = {8{fill[t]}};
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      tick(); in_valid8 = 1'b0;
      tick(); tick();
      checks++; if (out_valid8 !== 1'b1 || out_index8 !== 3'd0) begin errors++; $display("FAIL ties_%0d: got valid=%b index=%0d expected valid=1 index=0", t, out_valid8, out_index8); end
`ifdef ARGMAX_VALUE_OUT_EN
      checks++; if (out_value8 !== fill[t]) begin errors++; $display("FAIL ties_value_%0d: got %h expected %h", t, out_value8, fill[t]); end
`endif
    end
    tick();
  endtask

  task automatic test_n5();
    int v [5] = '{-7, -2, -9, -2, -1};
    for (int k = 0; k < 5; k++) in_data5[k*DW +: DW] = v[k];
    in_valid5 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) in_valid5 = 1'b0;
      checks++; if (out_valid5 !== (c == 3)) begin errors++; $display("FAIL n5_latency_c%0d: got %b expected %b", c, out_valid5, (c == 3)); end
    end
    checks++; if (out_index5 !== 3'd4) begin errors++; $display("FAIL n5_index: got %0d expected 4", out_index5); end
`ifdef ARGMAX_VALUE_OUT_EN
    checks++; if (out_value5 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL n5_value: got %h expected ffffffff", out_value5); end
`endif
    // All scores at the minimum: padding must not win.
    in_data5 = {5{32'h8000_0000}};
    in_valid5 = 1'b1;
    tick(); in_valid5 = 1'b0;
    tick(); tick();
    checks++; if (out_valid5 !== 1'b1 || out_index5 !== 3'd0) begin errors++; $display("FAIL n5_min_pad: got valid=%b index=%0d expected valid=1 index=0", out_valid5, out_index5); end
    tick();
  endtask

  task automatic test_sign();
    logic [DW-1:0] lo [4];
    logic [DW-1:0] hi [4];
    logic          exp [4];
    lo[0] = 32'hFFFF_FFFF; hi[0] = 32'd1;          exp[0] = 1'b1;
    lo[1] = 32'd7;         hi[1] = 32'd7;          exp[1] = 1'b0;
    lo[2] = 32'hFFFF_FFFB; hi[2] = 32'hFFFF_FFFA;  exp[2] = 1'b0;
    lo[3] = 32'h8000_0000; hi[3] = 32'h7FFF_FFFF;  exp[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      in_data2 = {hi[t], lo[t]};
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      checks++; if (out_valid2 !== 1'b1 || out_index2 !== exp[t]) begin errors++; $display("FAIL sign_%0d: got valid=%b index=%0d expected valid=1 index=%0d", t, out_valid2, out_index2, exp[t]); end
`ifdef ARGMAX_VALUE_OUT_EN
      checks++; if (out_value2 !== (exp[t] ? hi[t] : lo[t])) begin errors++; $display("FAIL sign_value_%0d: got %h expected %h", t, out_value2, exp[t] ? hi[t] : lo[t]); end
`endif
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         rcv  = 0;
    int         v [8];
    logic       held = 1'b0;
    logic [2:0] held_idx = '0;
    logic [2:0] exp_idx;
    logic       exp_ready, acc, cons;
    for (int cyc = 0; cyc < 80 && rcv < 10; cyc++) begin
      out_ready8 = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid8  = (sent < 10);
      for (int k = 0; k < 8; k++) v[k] = sent;
      v[(3*sent + 1) % 8] = 100 + sent;
      drive8(v);
      #1;
      if (held) begin
        checks++; if (out_valid8 !== 1'b1 || out_index8 !== held_idx) begin errors++; $display("FAIL b2b_hold: got valid=%b index=%0d expected valid=1 index=%0d", out_valid8, out_index8, held_idx); end
      end
      exp_ready = !(out_valid8 && !out_ready8);
      checks++; if (in_ready8 !== exp_ready) begin errors++; $display("FAIL b2b_in_ready: got %b expected %b", in_ready8, exp_ready); end
      acc  = in_valid8 && in_ready8;
      cons = out_valid8 && out_ready8;
      if (cons) begin
        exp_idx = 3'((3*rcv + 1) % 8);
        checks++; if (out_index8 !== exp_idx) begin errors++; $display("FAIL b2b_order_%0d: got index %0d expected %0d", rcv, out_index8, exp_idx); end
`ifdef ARGMAX_VALUE_OUT_EN
        checks++; if (out_value8 !== 32'(100 + rcv)) begin errors++; $display("FAIL b2b_value_%0d: got %0d expected %0d", rcv, out_value8, 100 + rcv); end
`endif
        rcv++;
      end
      held     = out_valid8 && !out_ready8;
      held_idx = out_index8;
      tick();
      if (acc) sent++;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    checks++; if (sent != 10 || rcv != 10) begin errors++; $display("FAIL b2b_count: got sent=%0d rcv=%0d expected 10/10", sent, rcv); end
    repeat (4) tick();
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", out_valid8); end
  endtask

  task automatic test_reset_midstream();
    out_ready8 = 1'b1;
    drive8('{1, 1, 1, 1, 1, 50, 1, 1});
    in_valid8 = 1'b1;
    tick();
    drive8('{2, 60, 2, 2, 2, 2, 2, 2});
    tick();
    drive8('{3, 3, 3, 70, 3, 3, 3, 3});
    resetn = 1'b0;
    tick();
    checks++; if (out_valid8 !== 1'b0 || out_index8 !== 3'd0) begin errors++; $display("FAIL midreset: got valid=%b index=%0d expected valid=0 index=0", out_valid8, out_index8); end
    tick();
    resetn = 1'b1; in_valid8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL midreset_flush_c%0d: got valid=%b expected 0", c, out_valid8); end
    end
    drive8('{4, 4, 4, 4, 4, 4, 77, 4});
    in_valid8 = 1'b1;
    tick(); in_valid8 = 1'b0;
    tick(); tick();
    checks++; if (out_valid8 !== 1'b1 || out_index8 !== 3'd6) begin errors++; $display("FAIL midreset_post: got valid=%b index=%0d expected valid=1 index=6", out_valid8, out_index8); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_n5();
    test_sign();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
